// File: rtl/wb_mem_arbiter.sv
// Two-master to one-slave classic Wishbone arbiter for the shared on-chip RAM.
// Master 0 is the memory-stage data port and master 1 is the instruction-fetch port.
// A master keeps the bus from grant until it drops cyc. Grants are round-robin.
// An optional watchdog aborts a strobed access that the slave never answers.
module wb_mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            iClk,
    input  logic            nRst,
    // master 0 (data)
    input  logic            iM0_cyc,
    input  logic            iM0_stb,
    input  logic            iM0_we,
    input  logic [DW/8-1:0] iM0_sel,
    input  logic [AW-1:0]   iM0_adr,
    input  logic [DW-1:0]   iM0_dat,
    output logic [DW-1:0]   oM0_dat,
    output logic            oM0_ack,
    output logic            oM0_err,
    // master 1 (fetch)
    input  logic            iM1_cyc,
    input  logic            iM1_stb,
    input  logic            iM1_we,
    input  logic [DW/8-1:0] iM1_sel,
    input  logic [AW-1:0]   iM1_adr,
    input  logic [DW-1:0]   iM1_dat,
    output logic [DW-1:0]   oM1_dat,
    output logic            oM1_ack,
    output logic            oM1_err,
    // slave
    output logic            oS_cyc,
    output logic            oS_stb,
    output logic            oS_we,
    output logic [DW/8-1:0] oS_sel,
    output logic [AW-1:0]   oS_adr,
    output logic [DW-1:0]   oS_dat,
    input  logic [DW-1:0]   iS_dat,
    input  logic            iS_ack,
    input  logic            iS_err,
    // status
    output logic [1:0]      oGrant,
    output logic            oTimeout
);

    localparam int SW = DW / 8;
    // Keep the counter at least one bit wide so a disabled watchdog still elaborates.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    grant_q, grant_d;

    // Current owner's request signals
    logic          own_cyc_s;
    logic          own_stb_s;
    logic          own_we_s;
    logic [SW-1:0] own_sel_s;
    logic [AW-1:0] own_adr_s;
    logic [DW-1:0] own_dat_s;

    // Response destined for the current owner
    logic          rsp_ack_s;
    logic          rsp_err_s;
    logic [DW-1:0] rsp_dat_s;

    // Winner chosen in IDLE
    logic          pick_s;

    // Select the request fields of whichever master currently owns the bus
    always_comb begin
        if (owner_q) begin
            own_cyc_s = iM1_cyc;
            own_stb_s = iM1_stb;
            own_we_s  = iM1_we;
            own_sel_s = iM1_sel;
            own_adr_s = iM1_adr;
            own_dat_s = iM1_dat;
        end else begin
            own_cyc_s = iM0_cyc;
            own_stb_s = iM0_stb;
            own_we_s  = iM0_we;
            own_sel_s = iM0_sel;
            own_adr_s = iM0_adr;
            own_dat_s = iM0_dat;
        end
    end

    // Round-robin pick: a lone requester wins, a tie goes to the master not granted last
    always_comb begin
        if (iM0_cyc && iM1_cyc) begin
            pick_s = ~last_q;
        end else begin
            pick_s = iM1_cyc;
        end
    end

    // Next-state, grant and watchdog counter computation
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (iM0_cyc || iM1_cyc) begin
                    owner_d = pick_s;
                    last_d  = pick_s;
                    grant_d = pick_s ? 2'b10 : 2'b01;
                    state_d = ST_OWN;
                end else begin
                    grant_d = 2'b00;
                end
            end
            ST_OWN: begin
                if (!own_cyc_s) begin
                    // Tenure ends; an ack in this same cycle was already forwarded.
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    cnt_d   = '0;
                end else if (iS_ack || iS_err || !own_stb_s) begin
                    cnt_d = '0;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d = ST_ABORT;
                    cnt_d   = '0;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CW'(1'b1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_ABORT: begin
                // Single-cycle error pulse, then wait for the master to let go.
                state_d = ST_DRAIN;
                cnt_d   = '0;
            end
            ST_DRAIN: begin
                cnt_d = '0;
                if (!own_cyc_s) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    // Slave-side drive: pass the owner through only while it holds a live tenure
    always_comb begin
        case (state_q)
            ST_OWN: begin
                oS_cyc = own_cyc_s;
                oS_stb = own_stb_s;
                oS_we  = own_we_s;
                oS_sel = own_sel_s;
                oS_adr = own_adr_s;
                oS_dat = own_dat_s;
            end
            default: begin
                oS_cyc = 1'b0;
                oS_stb = 1'b0;
                oS_we  = 1'b0;
                oS_sel = '0;
                oS_adr = '0;
                oS_dat = '0;
            end
        endcase
    end

    // Response for the owner: slave passthrough in OWN, forced error in ABORT, silence otherwise
    always_comb begin
        case (state_q)
            ST_OWN: begin
                rsp_ack_s = iS_ack;
                rsp_err_s = iS_err;
                rsp_dat_s = iS_dat;
            end
            ST_ABORT: begin
                rsp_ack_s = 1'b0;
                rsp_err_s = 1'b1;
                rsp_dat_s = '0;
            end
            default: begin
                rsp_ack_s = 1'b0;
                rsp_err_s = 1'b0;
                rsp_dat_s = '0;
            end
        endcase
    end

    // Steer the response to the owner; the other master sees all zeros
    always_comb begin
        if (owner_q) begin
            oM0_ack = 1'b0;
            oM0_err = 1'b0;
            oM0_dat = '0;
            oM1_ack = rsp_ack_s;
            oM1_err = rsp_err_s;
            oM1_dat = rsp_dat_s;
        end else begin
            oM0_ack = rsp_ack_s;
            oM0_err = rsp_err_s;
            oM0_dat = rsp_dat_s;
            oM1_ack = 1'b0;
            oM1_err = 1'b0;
            oM1_dat = '0;
        end
    end

    assign oGrant   = grant_q;
    assign oTimeout = (state_q == ST_ABORT);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter: expected master responses and grant
// transitions are queued by the stimulus and popped by an independent monitor.
module tb_wb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam int SLV_NONE  = 0;
    localparam int SLV_ACK   = 1;
    localparam int SLV_ERR   = 2;
    localparam int SLV_NEVER = 3;
    localparam int SLV_FORCE = 4;

    logic          iClk = 1'b0;
    logic          nRst = 1'b0;
    logic          iM0_cyc = 1'b0, iM0_stb = 1'b0, iM0_we = 1'b0;
    logic [3:0]    iM0_sel = 4'h0;
    logic [31:0]   iM0_adr = 32'h0, iM0_dat = 32'h0;
    logic [31:0]   oM0_dat;
    logic          oM0_ack, oM0_err;
    logic          iM1_cyc = 1'b0, iM1_stb = 1'b0, iM1_we = 1'b0;
    logic [3:0]    iM1_sel = 4'h0;
    logic [31:0]   iM1_adr = 32'h0, iM1_dat = 32'h0;
    logic [31:0]   oM1_dat;
    logic          oM1_ack, oM1_err;
    logic          oS_cyc, oS_stb, oS_we;
    logic [3:0]    oS_sel;
    logic [31:0]   oS_adr, oS_dat;
    logic [31:0]   iS_dat = 32'h0;
    logic          iS_ack = 1'b0, iS_err = 1'b0;
    logic [1:0]    oGrant;
    logic          oTimeout;

    int slv_mode = SLV_NONE;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic        tmo;
        logic        scyc;
        logic [31:0] sadr;
    } resp_t;

    typedef struct {
        logic [1:0] g;
        int         gap;
    } gnt_t;

    resp_t q0[$];
    resp_t q1[$];
    gnt_t  gq[$];

    wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .iClk(iClk), .nRst(nRst),
        .iM0_cyc(iM0_cyc), .iM0_stb(iM0_stb), .iM0_we(iM0_we), .iM0_sel(iM0_sel),
        .iM0_adr(iM0_adr), .iM0_dat(iM0_dat), .oM0_dat(oM0_dat), .oM0_ack(oM0_ack), .oM0_err(oM0_err),
        .iM1_cyc(iM1_cyc), .iM1_stb(iM1_stb), .iM1_we(iM1_we), .iM1_sel(iM1_sel),
        .iM1_adr(iM1_adr), .iM1_dat(iM1_dat), .oM1_dat(oM1_dat), .oM1_ack(oM1_ack), .oM1_err(oM1_err),
        .oS_cyc(oS_cyc), .oS_stb(oS_stb), .oS_we(oS_we), .oS_sel(oS_sel), .oS_adr(oS_adr),
        .oS_dat(oS_dat), .iS_dat(iS_dat), .iS_ack(iS_ack), .iS_err(iS_err),
        .oGrant(oGrant), .oTimeout(oTimeout)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic resp_t mk(input logic ack, input logic err, input logic [31:0] dat,
                                 input logic tmo, input logic scyc, input logic [31:0] sadr);
        resp_t r;
        r.ack = ack; r.err = err; r.dat = dat; r.tmo = tmo; r.scyc = scyc; r.sadr = sadr;
        return r;
    endfunction

    function automatic gnt_t gx(input logic [1:0] g, input int gap);
        gnt_t e;
        e.g = g; e.gap = gap;
        return e;
    endfunction

    // Slave model: responds one cycle after it sees a strobe
    initial begin : slave
        logic req;
        forever begin
            @(negedge iClk);
            req = oS_cyc && oS_stb && !iS_ack && !iS_err;
            @(posedge iClk);
            #2;
            iS_ack = ((slv_mode == SLV_ACK) && req) || (slv_mode == SLV_FORCE);
            iS_err = (slv_mode == SLV_ERR) && req;
        end
    end

    // Monitor: pops expected responses and grant transitions as they appear
    initial begin : monitor
        logic [1:0] prev_g;
        int         zrun;
        resp_t      r;
        gnt_t       e;
        prev_g = 2'b00;
        zrun   = 0;
        forever begin
            @(negedge iClk);
            if (oM0_ack || oM0_err) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL m0_unexpected_resp actual=ack%0b_err%0b required=none", oM0_ack, oM0_err);
                end else begin
                    r = q0.pop_front();
                    chk("m0_ack", oM0_ack, r.ack);
                    chk("m0_err", oM0_err, r.err);
                    chk("m0_dat", oM0_dat, r.dat);
                    chk("m0_timeout", oTimeout, r.tmo);
                    chk("m0_s_cyc", oS_cyc, r.scyc);
                    chk("m0_s_adr", oS_adr, r.sadr);
                    chk("m1_quiet", oM1_dat | {30'd0, oM1_ack, oM1_err}, 32'd0);
                end
            end
            if (oM1_ack || oM1_err) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL m1_unexpected_resp actual=ack%0b_err%0b required=none", oM1_ack, oM1_err);
                end else begin
                    r = q1.pop_front();
                    chk("m1_ack", oM1_ack, r.ack);
                    chk("m1_err", oM1_err, r.err);
                    chk("m1_dat", oM1_dat, r.dat);
                    chk("m1_timeout", oTimeout, r.tmo);
                    chk("m1_s_cyc", oS_cyc, r.scyc);
                    chk("m1_s_adr", oS_adr, r.sadr);
                    chk("m0_quiet", oM0_dat | {30'd0, oM0_ack, oM0_err}, 32'd0);
                end
            end
            if (oGrant !== prev_g) begin
                if (gq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL grant_unexpected actual=%b required=%b", oGrant, prev_g);
                end else begin
                    e = gq.pop_front();
                    chk("grant_seq", oGrant, e.g);
                    if (e.gap >= 0) begin
                        chk("dead_cycles", zrun, e.gap);
                    end
                end
                zrun   = (oGrant == 2'b00) ? 1 : 0;
                prev_g = oGrant;
            end else if (oGrant == 2'b00) begin
                zrun++;
            end else begin
                zrun = 0;
            end
        end
    end

    task automatic access(input int m, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input resp_t exp);
        logic done;
        @(posedge iClk);
        #1;
        if (m == 0) begin
            q0.push_back(exp);
            iM0_cyc = 1'b1; iM0_stb = 1'b1; iM0_we = we; iM0_sel = 4'hF; iM0_adr = adr; iM0_dat = dat;
        end else begin
            q1.push_back(exp);
            iM1_cyc = 1'b1; iM1_stb = 1'b1; iM1_we = we; iM1_sel = 4'hF; iM1_adr = adr; iM1_dat = dat;
        end
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge iClk);
            done = (m == 0) ? (oM0_ack || oM0_err) : (oM1_ack || oM1_err);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL m%0d_access_bound actual=no_response required=response", m);
        end
        @(posedge iClk);
        #1;
        if (m == 0) begin
            iM0_cyc = 1'b0; iM0_stb = 1'b0; iM0_we = 1'b0;
        end else begin
            iM1_cyc = 1'b0; iM1_stb = 1'b0; iM1_we = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(posedge iClk);
        #1;
        nRst = 1'b0;
        iM0_cyc = 1'b0; iM0_stb = 1'b0; iM0_we = 1'b0;
        iM1_cyc = 1'b0; iM1_stb = 1'b0; iM1_we = 1'b0;
        slv_mode = SLV_NONE;
        repeat (2) @(posedge iClk);
        #1;
        nRst = 1'b1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   nstb;
        logic done;

        // Reset values
        #12;
        chk("rst_grant", oGrant, 2'b00);
        chk("rst_timeout", oTimeout, 1'b0);
        chk("rst_s_cyc", oS_cyc, 1'b0);
        chk("rst_m_resp", {28'd0, oM0_ack, oM0_err, oM1_ack, oM1_err}, 32'd0);
        apply_reset();

        // M0 alone, write with ack one cycle after strobe
        slv_mode = SLV_ACK;
        iS_dat   = 32'hA5A5_0001;
        gq.push_back(gx(2'b01, -1));
        gq.push_back(gx(2'b00, -1));
        fork
            access(0, 1'b1, 32'h10, 32'hDEADBEEF, mk(1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b1, 32'h10));
            begin
                @(posedge iClk);
                @(negedge iClk);
                chk("t1_grant_idle", oGrant, 2'b00);
                @(negedge iClk);
                chk("t1_grant_lat", oGrant, 2'b01);
                chk("t1_s_adr", oS_adr, 32'h10);
                chk("t1_s_dat", oS_dat, 32'hDEADBEEF);
                chk("t1_s_we", oS_we, 1'b1);
            end
        join
        repeat (3) @(posedge iClk);

        // Simultaneous first request after reset: M0 wins, M1 follows after one dead cycle
        apply_reset();
        slv_mode = SLV_ACK;
        iS_dat   = 32'h0000_BEEF;
        gq.push_back(gx(2'b01, -1));
        gq.push_back(gx(2'b00, -1));
        gq.push_back(gx(2'b10, 1));
        gq.push_back(gx(2'b00, -1));
        fork
            access(0, 1'b1, 32'h20, 32'h1111_2222, mk(1'b1, 1'b0, 32'h0000_BEEF, 1'b0, 1'b1, 32'h20));
            access(1, 1'b0, 32'h30, 32'h0, mk(1'b1, 1'b0, 32'h0000_BEEF, 1'b0, 1'b1, 32'h30));
        join
        repeat (3) @(posedge iClk);

        // Saturation: both keep requesting, grants alternate with one dead cycle
        apply_reset();
        slv_mode = SLV_ACK;
        iS_dat   = 32'h1234_5678;
        gq.push_back(gx(2'b01, -1));
        gq.push_back(gx(2'b00, -1));
        gq.push_back(gx(2'b10, 1));
        gq.push_back(gx(2'b00, -1));
        gq.push_back(gx(2'b01, 1));
        gq.push_back(gx(2'b00, -1));
        gq.push_back(gx(2'b10, 1));
        gq.push_back(gx(2'b00, -1));
        fork
            begin
                access(0, 1'b0, 32'h100, 32'h0, mk(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'h100));
                access(0, 1'b0, 32'h104, 32'h0, mk(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'h104));
            end
            begin
                access(1, 1'b0, 32'h200, 32'h0, mk(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'h200));
                access(1, 1'b0, 32'h204, 32'h0, mk(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'h204));
            end
        join
        repeat (3) @(posedge iClk);

        // Timeout: slave never answers M1, abort after four strobed cycles
        apply_reset();
        slv_mode = SLV_NEVER;
        gq.push_back(gx(2'b10, -1));
        q1.push_back(mk(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0));
        @(posedge iClk);
        #1;
        iM1_cyc = 1'b1; iM1_stb = 1'b1; iM1_we = 1'b0; iM1_sel = 4'hF; iM1_adr = 32'h40;
        nstb = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge iClk);
            if (oM1_err) begin
                done = 1'b1;
            end else if (oS_stb) begin
                nstb++;
            end
        end
        chk("to_seen", done, 1'b1);
        chk("to_strobed_cycles", nstb, 4);
        chk("to_s_stb", oS_stb, 1'b0);
        slv_mode = SLV_FORCE;
        repeat (2) begin
            @(negedge iClk);
            chk("to_drain_ack", oM1_ack, 1'b0);
            chk("to_drain_err", oM1_err, 1'b0);
            chk("to_drain_pulse", oTimeout, 1'b0);
            chk("to_drain_grant", oGrant, 2'b10);
        end
        slv_mode = SLV_NONE;
        gq.push_back(gx(2'b00, -1));
        @(posedge iClk);
        #1;
        iM1_cyc = 1'b0; iM1_stb = 1'b0;
        repeat (2) @(negedge iClk);
        chk("to_grant_release", oGrant, 2'b00);

        // Reset while M0 owns with strobe high
        apply_reset();
        slv_mode = SLV_NEVER;
        gq.push_back(gx(2'b01, -1));
        @(posedge iClk);
        #1;
        iM0_cyc = 1'b1; iM0_stb = 1'b1; iM0_sel = 4'hF; iM0_adr = 32'h50;
        repeat (2) @(negedge iClk);
        chk("mr_s_cyc_before", oS_cyc, 1'b1);
        gq.push_back(gx(2'b00, -1));
        #2;
        nRst = 1'b0;
        #1;
        chk("mr_s_cyc_async", oS_cyc, 1'b0);
        chk("mr_grant_async", oGrant, 2'b00);
        iM0_stb = 1'b0;
        iM1_cyc = 1'b1;
        gq.push_back(gx(2'b01, -1));
        @(posedge iClk);
        #1;
        nRst = 1'b1;
        repeat (2) @(negedge iClk);
        chk("mr_grant_m0_first", oGrant, 2'b01);
        gq.push_back(gx(2'b00, -1));
        gq.push_back(gx(2'b10, 1));
        @(posedge iClk);
        #1;
        iM0_cyc = 1'b0;
        repeat (3) @(negedge iClk);
        chk("mr_grant_m1_next", oGrant, 2'b10);
        gq.push_back(gx(2'b00, -1));
        @(posedge iClk);
        #1;
        iM1_cyc = 1'b0;
        repeat (3) @(posedge iClk);

        // Slave error passthrough on an M0 write
        apply_reset();
        slv_mode = SLV_ERR;
        iS_dat   = 32'hCAFE_0001;
        gq.push_back(gx(2'b01, -1));
        gq.push_back(gx(2'b00, -1));
        access(0, 1'b1, 32'h80, 32'h55AA_55AA, mk(1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b1, 32'h80));
        repeat (3) @(posedge iClk);

        // Every queued expectation must have been consumed
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("gq_drained", gq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
Two-master to one-slave Wishbone (classic, non-pipelined) arbiter that shares the on-chip RAM block between the data port (memory stage, master 0) and the instruction-fetch port (master 1). Bus tenure runs from grant until the owning master drops cyc. Arbitration is round-robin, with a per-access timeout that aborts a hung slave with err. Sits between the memory-stage/fetch Wishbone masters and the single RAM slave.

Parameters:
AW, 32, address width
DW, 32, data width (sel width = DW/8)
TIMEOUT_CYCLES, 16, max cycles a strobed access may wait for ack/err; 0 disables timeout

Ports:
iClk  in  1  clock
nRst  in  1  reset, asynchronous, active-low
iM0_cyc, iM0_stb, iM0_we  in  1 each  master 0 (data) bus cycle, strobe, write
iM0_sel  in  DW/8  master 0 byte select
iM0_adr  in  AW  master 0 address
iM0_dat  in  DW  master 0 write data
oM0_dat  out  DW  master 0 read data
oM0_ack, oM0_err  out  1 each  master 0 ack / error
iM1_* / oM1_*  same set as master 0  master 1 (fetch)
oS_cyc, oS_stb, oS_we  out  1 each  to slave
oS_sel  out  DW/8  to slave
oS_adr  out  AW  to slave
oS_dat  out  DW  write data to slave
iS_dat  in  DW  slave read data
iS_ack, iS_err  in  1 each  slave ack / error
oGrant  out  2  one-hot current owner (bit0 = M0, bit1 = M1), registered
oTimeout  out  1  one-cycle pulse when an access is aborted

Behaviour:
- States: IDLE, OWN, ABORT, DRAIN. Registers: state, owner (1b), last (1b, last granted), wait counter of width $clog2(TIMEOUT_CYCLES+1).
- Reset (async, nRst low): state=IDLE, last=1 (M0 wins the first tie), counter=0, oGrant=2'b00, oTimeout=0. All slave-side outputs and all master ack/err/dat read as 0 while in reset.
- IDLE: slave outputs all 0. At the clock edge, if exactly one iMx_cyc is high, grant it. If both are high, grant the master != last. On grant: owner<=x, last<=x, oGrant<=onehot(x), state<=OWN. Grant latency is 1 cycle from cyc assertion to oS_cyc.
- OWN: oS_cyc/stb/we/sel/adr/dat follow the owner's inputs combinationally. Owner receives oMx_ack=iS_ack, oMx_err=iS_err, oMx_dat=iS_dat. Non-owner receives ack=0, err=0, dat=0. Non-owner requests are held off; no buffering.
- OWN exit: when owner cyc=0 at a clock edge, state<=IDLE and oGrant<=0. At least one dead cycle always separates tenures. Re-arbitration happens in IDLE.
- Ack and cyc drop in the same cycle: the ack is still delivered (combinational path), then exit to IDLE.
- Timeout (TIMEOUT_CYCLES>0): in OWN, the counter increments each cycle with owner stb=1 and iS_ack=iS_err=0. It clears on ack, on err, or when stb=0. When counter==TIMEOUT_CYCLES-1 and there is still no ack/err, state<=ABORT.
- ABORT (1 cycle): oS_cyc=oS_stb=0, owner oMx_err=1, oMx_ack=0, oTimeout=1. Next state is DRAIN.
- DRAIN: slave outputs 0. Owner ack/err=0. Stays until owner cyc=0, then state<=IDLE and oGrant<=0.
- Slave ack/err arriving in ABORT/DRAIN is ignored (not forwarded).
- oTimeout is high only in the ABORT state (decoded), 0 otherwise.
- last updates only on grant, so a single requester may be granted repeatedly.

Test Plan:
- Reset then M0 only: M0 cyc/stb, we=1, adr=0x10, dat=0xDEADBEEF, slave acks 1 cycle after oS_stb -> oGrant=01 one cycle after cyc; oS_adr=0x10; oM0_ack pulses once; M1 ack stays 0.
- Simultaneous first request: M0 and M1 raise cyc in the same cycle after reset -> M0 granted first (oGrant=01). After M0 drops cyc: one IDLE cycle, then oGrant=10.
- Round-robin under saturation: both hold cyc, each drops after one acked read -> grants alternate 01,10,01,10 with exactly one IDLE cycle between tenures. M1 read gets iS_dat=0x12345678 on oM1_dat; oM0_dat=0 meanwhile.
- Timeout: TIMEOUT_CYCLES=4, slave never acks M1 read -> after 4 strobed cycles, one-cycle oM1_err=1 and oTimeout=1 with oS_cyc=0. oGrant stays 10 until M1 drops cyc, then returns to 00. Late iS_ack is not forwarded.
- Reset mid-tenure: nRst pulled low while M0 owns with stb high -> oS_cyc and oGrant go to 0 asynchronously. After release with both masters requesting, M0 is granted first.
- Slave error passthrough: slave returns iS_err=1 for an M0 write -> oM0_err=1 in the same cycle, counter cleared, oTimeout stays 0.
